// File: rtl/uart_pkg.sv
// Shared UART definitions: the FSM state encoding used by both the
// transmitter and the receiver, and small helpers for bit timing and parity.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Clock cycles per serial bit; integer truncation is intentional.
   function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

   // Parity bit over a byte: even parity when odd_sel=0, odd parity otherwise.
   function automatic logic calc_parity(input logic [7:0] data, input logic odd_sel);
      return (^data) ^ odd_sel;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and status bundle between a byte producer and the UART
// transmitter. The serial line itself travels in the bundle as well.
interface uart_tx_if;

   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx;
   logic       busy;
   logic       done_tx;

   // Byte producer side.
   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready,
      input  tx,
      input  busy,
      input  done_tx
   );

   // Transmitter side.
   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready,
      output tx,
      output busy,
      output done_tx
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period clock enable. bit_tick_o is high on the last cycle of every
// CLKS_PER_BIT-cycle period; pre_tick_o is high on the cycle before that so
// the transmitter can register a pulse that lines up with the tick.
// clear_i restarts the period so a new frame starts on a full bit time.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic bit_tick_o,
   output logic pre_tick_o
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE_CNT  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: restart on clear, wrap at the end of each bit period.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Period counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bit_tick_o = (cnt_q == LAST_CNT);
   assign pre_tick_o = (cnt_q == PRE_CNT);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// one stop bit. All timing comes from a clock-enable counter on clk; the
// serial line and the completion pulse are registered.
module uart_tx
   import uart_pkg::*;
#(
   parameter int clk_freq   = 1000000,
   parameter int baud_rate  = 9600,
   parameter int parity_en  = 0,
   parameter int parity_odd = 0
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus
);

   localparam int   CLKS_PER_BIT = calc_clks_per_bit(clk_freq, baud_rate);
   localparam bit   PAR_EN       = (parity_en != 0);
   localparam logic PAR_ODD      = (parity_odd != 0) ? 1'b1 : 1'b0;

   // A bit period shorter than two clocks leaves no room for the pre-tick.
   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_rate
         $fatal(1, "uart_tx: clk_freq/baud_rate must be at least 2");
      end
   endgenerate

   uart_state_e state_q;
   logic [7:0]  shift_q;
   logic [2:0]  idx_q;
   logic        par_q;
   logic        tx_q;
   logic        done_q;

   logic        bit_tick_s;
   logic        pre_tick_s;
   logic        accept_s;

   assign accept_s = (state_q == ST_IDLE) && bus.tx_valid;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud_gen (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (accept_s),
      .bit_tick_o(bit_tick_s),
      .pre_tick_o(pre_tick_s)
   );

   // Frame sequencer; tx is loaded with the next bit value on each transition
   // so the line changes exactly at bit boundaries.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shift_q <= 8'h00;
         idx_q   <= 3'd0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (bus.tx_valid) begin
                  shift_q <= bus.tx_data;
                  par_q   <= calc_parity(bus.tx_data, PAR_ODD);
                  idx_q   <= 3'd0;
                  tx_q    <= 1'b0;
                  state_q <= ST_START;
               end
            end
            ST_START: begin
               if (bit_tick_s) begin
                  idx_q   <= 3'd0;
                  tx_q    <= shift_q[0];
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_tick_s) begin
                  if (idx_q == 3'd7) begin
                     if (PAR_EN) begin
                        tx_q    <= par_q;
                        state_q <= ST_PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        state_q <= ST_STOP;
                     end
                  end else begin
                     shift_q <= {1'b0, shift_q[7:1]};
                     idx_q   <= idx_q + 3'd1;
                     tx_q    <= shift_q[1];
                  end
               end
            end
            ST_PARITY: begin
               if (bit_tick_s) begin
                  tx_q    <= 1'b1;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               // Registered so the pulse coincides with the last stop cycle.
               if (pre_tick_s) begin
                  done_q <= 1'b1;
               end
               if (bit_tick_s) begin
                  tx_q    <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.tx       = tx_q;
   assign bus.done_tx  = done_q;
   assign bus.tx_ready = (state_q == ST_IDLE);
   assign bus.busy     = (state_q != ST_IDLE);

endmodule
